// File: rtl/hamming_code_encoder_pkg.sv
// Shared constants and types for the Hamming(7,4) encoder slice.
// Bit positions follow the x[6:0] codeword layout.
package hamming_code_encoder_pkg;

  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;

  localparam logic [2:0] NO_INJECT = 3'd7;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } occ_t;

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming(7,4) encoder.
// odd=1 inverts all three parity bits.
module hamming_parity_gen
  import hamming_code_encoder_pkg::*;
(
  input  logic [3:0] d,
  input  logic       odd,
  output logic [6:0] x
);

  always_comb begin
    x     = '0;
    x[D0] = d[0];
    x[D1] = d[1];
    x[D2] = d[2];
    x[D3] = d[3];
    x[P1] = d[0] ^ d[1] ^ d[3] ^ odd;
    x[P2] = d[0] ^ d[2] ^ d[3] ^ odd;
    x[P4] = d[1] ^ d[2] ^ d[3] ^ odd;
  end

endmodule

// File: rtl/hamming_code_encoder.sv
// Hamming(7,4) encoder with a 2-entry output FIFO and word counter.
// Define HAMMING_ERR_INJECT_EN to add the inj_pos bit-flip port.
module hamming_code_encoder
  import hamming_code_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [2:0]  inj_pos,
`endif
  input  logic        select,
  input  logic [3:0]  data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  code_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] word_count
);

  occ_t       occ;
  logic [6:0] enc;
  logic [6:0] flip;
  logic [6:0] cw;
  logic [6:0] tail;
  logic       push;
  logic       pop;

  hamming_parity_gen u_gen (
    .d   (data_in),
    .odd (select),
    .x   (enc)
  );

  always_comb begin
    flip = '0;
`ifdef HAMMING_ERR_INJECT_EN
    if (inj_pos != NO_INJECT)
      flip[inj_pos] = 1'b1;
`endif
  end

  assign cw   = enc ^ flip;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // code_out is the head slot; tail only ever holds the second word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ        <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      code_out   <= '0;
      tail       <= '0;
      word_count <= '0;
    end else begin
      if (push)
        word_count <= word_count + 16'd1;
      unique case (occ)
        EMPTY: begin
          if (push) begin
            code_out  <= cw;
            out_valid <= 1'b1;
            occ       <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            code_out <= cw;
          end else if (push) begin
            tail     <= cw;
            in_ready <= 1'b0;
            occ      <= FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            occ       <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            code_out <= tail;
            in_ready <= 1'b1;
            occ      <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end

endmodule
